// File: rtl/imem_instr_encoder.sv
// Packs decoded RV32I fields back into instruction words and streams them into IMEM
// through a sequential word-address write port, flagging immediates that cannot be encoded.
module imem_instr_encoder #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256,
   parameter int BASE   = 0
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [2:0]        ImmSrc,
   input  logic [6:0]        Opcode,
   input  logic [4:0]        Rd,
   input  logic [4:0]        Rs1,
   input  logic [4:0]        Rs2,
   input  logic [2:0]        Funct3,
   input  logic [6:0]        Funct7,
   input  logic [31:0]       Imm,
   output logic              WE,
   output logic [ADDR_W-1:0] WAddr,
   output logic [31:0]       WData,
   output logic [ADDR_W:0]   count,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [2:0]        err_code
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE);

   state_t             state;
   logic [ADDR_W-1:0]  ptr;
   logic signed [31:0] imm_p0;
   logic [31:0]        encWord_p0;
   logic [2:0]         chkCode_p0;
   logic               accept_p0;
   logic               vld_p1;
   logic [ADDR_W-1:0]  wAddr_p1;
   logic [31:0]        wData_p1;

   // True when every bit from msb upward is a copy of bit msb.
   function automatic logic fitsSigned(input logic signed [31:0] v, input int msb);
      logic signed [31:0] hi;
      hi = v >>> msb;
      return (hi == 32'sd0) || (hi == -32'sd1);
   endfunction

   function automatic logic [2:0] checkImm(input logic [2:0] src, input logic signed [31:0] v);
      logic [2:0] code;
      code = 3'd0;
      case (src)
         3'b001, 3'b010: if (!fitsSigned(v, 11)) code = 3'd1;
         3'b011: begin
            if (v[0])                   code = 3'd2;
            else if (!fitsSigned(v, 12)) code = 3'd1;
         end
         3'b100: if (v[11:0] != 12'd0) code = 3'd1;
         3'b101: begin
            if (v[0])                   code = 3'd2;
            else if (!fitsSigned(v, 20)) code = 3'd1;
         end
         3'b110, 3'b111: code = 3'd3;
         default: code = 3'd0;
      endcase
      return code;
   endfunction

   function automatic logic [31:0] encodeWord(
      input logic [2:0]         src,
      input logic [6:0]         op,
      input logic [4:0]         rd,
      input logic [4:0]         rs1,
      input logic [4:0]         rs2,
      input logic [2:0]         f3,
      input logic [6:0]         f7,
      input logic signed [31:0] v
   );
      logic [31:0] w;
      case (src)
         3'b001:  w = {v[11:0], rs1, f3, rd, op};
         3'b010:  w = {v[11:5], rs2, rs1, f3, v[4:0], op};
         3'b011:  w = {v[12], v[10:5], rs2, rs1, f3, v[4:1], v[11], op};
         3'b100:  w = {v[31:12], rd, op};
         3'b101:  w = {v[20], v[10:1], v[11], v[19:12], rd, op};
         default: w = {f7, rs2, rs1, f3, rd, op};
      endcase
      return w;
   endfunction

   assign imm_p0     = Imm;
   assign encWord_p0 = encodeWord(ImmSrc, Opcode, Rd, Rs1, Rs2, Funct3, Funct7, imm_p0);
   assign chkCode_p0 = checkImm(ImmSrc, imm_p0);
   assign in_ready   = (state == RUN) && (count < DEPTH_C);
   assign accept_p0  = in_valid && in_ready;

   // ---- p0 -> p1: accepted bundle becomes a registered IMEM write ----
   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         ptr      <= BASE_C;
         count    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         err_code <= 3'd0;
         vld_p1   <= 1'b0;
         wAddr_p1 <= BASE_C;
         wData_p1 <= 32'd0;
      end else begin
         vld_p1 <= 1'b0;
         done   <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state    <= RUN;
                  busy     <= 1'b1;
                  ptr      <= BASE_C;
                  count    <= '0;
                  err      <= 1'b0;
                  err_code <= 3'd0;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               if (accept_p0) begin
                  if (chkCode_p0 == 3'd0) begin
                     vld_p1   <= 1'b1;
                     wAddr_p1 <= ptr;
                     wData_p1 <= encWord_p0;
                     ptr      <= ptr + 1'b1;
                     count    <= count + 1'b1;
                  end else begin
                     err <= 1'b1;
                     if (err_code == 3'd0) err_code <= chkCode_p0;
                  end
                  if (in_last) state <= DRAIN;
               end else if (count >= DEPTH_C) begin
                  // Out of space before the loader marked its last word.
                  err   <= 1'b1;
                  if (err_code == 3'd0) err_code <= 3'd4;
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            DRAIN: begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign WE    = vld_p1;
   assign WAddr = wAddr_p1;
   assign WData = wData_p1;

endmodule

// File: tb/tb_imem_instr_encoder.sv
// Bench for imem_instr_encoder: directed cases with literal expectations, then random
// sessions checked cycle by cycle against a field-level behavioural model.
module tb_imem_instr_encoder;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 4;
   localparam int BASE   = 0;

   logic              CLK = 1'b0;
   logic              Reset = 1'b1;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic              in_last = 1'b0;
   logic [2:0]        ImmSrc = 3'd0;
   logic [6:0]        Opcode = 7'd0;
   logic [4:0]        Rd = 5'd0;
   logic [4:0]        Rs1 = 5'd0;
   logic [4:0]        Rs2 = 5'd0;
   logic [2:0]        Funct3 = 3'd0;
   logic [6:0]        Funct7 = 7'd0;
   logic [31:0]       Imm = 32'd0;
   logic              WE;
   logic [ADDR_W-1:0] WAddr;
   logic [31:0]       WData;
   logic [ADDR_W:0]   count;
   logic              busy;
   logic              done;
   logic              err;
   logic [2:0]        err_code;

   imem_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE(BASE)) dut (
      .CLK(CLK), .Reset(Reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_last(in_last), .ImmSrc(ImmSrc), .Opcode(Opcode), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2),
      .Funct3(Funct3), .Funct7(Funct7), .Imm(Imm), .WE(WE), .WAddr(WAddr), .WData(WData),
      .count(count), .busy(busy), .done(done), .err(err), .err_code(err_code)
   );

   always #5 CLK = ~CLK;

   int vectors = 0;
   int miscompares = 0;

   // Model: session phase 0 idle, 1 run, 2 drain, 3 done
   int          mPhase;
   int          mCnt;
   int          mPtr;
   logic        mErr;
   int          mCode;
   logic        mWE;
   logic [31:0] mWAddr;
   logic [31:0] mWData;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] refEncode();
      logic [31:0] op, rd, r1, r2, f3, f7, im;
      op = 32'(Opcode); rd = 32'(Rd); r1 = 32'(Rs1); r2 = 32'(Rs2);
      f3 = 32'(Funct3); f7 = 32'(Funct7); im = Imm;
      case (ImmSrc)
         3'd1: return op | (rd << 7) | (f3 << 12) | (r1 << 15) | ((im & 32'hFFF) << 20);
         3'd2: return op | ((im & 32'h1F) << 7) | (f3 << 12) | (r1 << 15) | (r2 << 20)
                      | (((im >> 5) & 32'h7F) << 25);
         3'd3: return op | (((im >> 11) & 32'h1) << 7) | (((im >> 1) & 32'hF) << 8)
                      | (f3 << 12) | (r1 << 15) | (r2 << 20)
                      | (((im >> 5) & 32'h3F) << 25) | (((im >> 12) & 32'h1) << 31);
         3'd4: return op | (rd << 7) | (im & 32'hFFFFF000);
         3'd5: return op | (rd << 7) | (((im >> 12) & 32'hFF) << 12) | (((im >> 11) & 32'h1) << 20)
                      | (((im >> 1) & 32'h3FF) << 21) | (((im >> 20) & 32'h1) << 31);
         default: return op | (rd << 7) | (f3 << 12) | (r1 << 15) | (r2 << 20) | (f7 << 25);
      endcase
   endfunction

   function automatic int refCheck();
      int v;
      v = $signed(Imm);
      if (ImmSrc >= 3'd6) return 3;
      case (ImmSrc)
         3'd1, 3'd2: return (v < -2048 || v > 2047) ? 1 : 0;
         3'd3: begin
            if (Imm[0]) return 2;
            return (v < -4096 || v > 4095) ? 1 : 0;
         end
         3'd4: return (Imm[11:0] != 12'd0) ? 1 : 0;
         3'd5: begin
            if (Imm[0]) return 2;
            return (v < -1048576 || v > 1048575) ? 1 : 0;
         end
         default: return 0;
      endcase
   endfunction

   task automatic modelReset();
      mPhase = 0; mCnt = 0; mPtr = BASE; mErr = 1'b0; mCode = 0;
      mWE = 1'b0; mWAddr = 32'(BASE); mWData = 32'd0;
   endtask

   task automatic modelStep();
      int c;
      mWE = 1'b0;
      if (Reset) begin
         modelReset();
         return;
      end
      case (mPhase)
         0, 3: begin
            if (start) begin
               mPhase = 1; mCnt = 0; mPtr = BASE; mErr = 1'b0; mCode = 0;
            end else mPhase = 0;
         end
         1: begin
            if (in_valid && mCnt < DEPTH) begin
               c = refCheck();
               if (c == 0) begin
                  mWE = 1'b1;
                  mWAddr = 32'(mPtr % (1 << ADDR_W));
                  mWData = refEncode();
                  mPtr++;
                  mCnt++;
               end else begin
                  mErr = 1'b1;
                  if (mCode == 0) mCode = c;
               end
               if (in_last) mPhase = 2;
            end else if (mCnt >= DEPTH) begin
               mErr = 1'b1;
               if (mCode == 0) mCode = 4;
               mPhase = 3;
            end
         end
         2: mPhase = 3;
         default: mPhase = 0;
      endcase
   endtask

   task automatic compareAll();
      check("in_ready", 32'(in_ready), 32'(mPhase == 1 && mCnt < DEPTH));
      check("WE", 32'(WE), 32'(mWE));
      if (mWE) begin
         check("WAddr", 32'(WAddr), mWAddr);
         check("WData", WData, mWData);
      end
      check("count", 32'(count), 32'(mCnt));
      check("busy", 32'(busy), 32'(mPhase == 1 || mPhase == 2));
      check("done", 32'(done), 32'(mPhase == 3));
      check("err", 32'(err), 32'(mErr));
      check("err_code", 32'(err_code), 32'(mCode));
   endtask

   task automatic cycle();
      @(posedge CLK);
      modelStep();
      @(negedge CLK);
      compareAll();
   endtask

   task automatic drive(input logic v, input logic l, input logic [2:0] src, input logic [6:0] op,
                        input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
      in_valid = v; in_last = l; ImmSrc = src; Opcode = op; Rd = rd; Rs1 = r1; Rs2 = r2;
      Funct3 = f3; Funct7 = f7; Imm = im;
   endtask

   task automatic idle();
      in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
   endtask

   function automatic logic [31:0] randImm();
      int bnd[12] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098,
                      1048574, 1048576, -1048576, 1};
      case ($urandom_range(0, 4))
         0: return $urandom;
         1: return 32'($urandom_range(0, 8191)) - 32'd4096;
         2: return $urandom & 32'hFFFFF000;
         3: return 32'(bnd[$urandom_range(0, 11)]);
         default: return (32'($urandom_range(0, 2047)) - 32'd1024) << 1;
      endcase
   endfunction

   task automatic randBundle();
      in_valid = ($urandom_range(0, 3) != 0);
      in_last  = ($urandom_range(0, 5) == 0);
      start    = ($urandom_range(0, 15) == 0);
      ImmSrc   = ($urandom_range(0, 9) == 0) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(0, 5));
      Opcode   = 7'($urandom);
      Rd       = 5'($urandom);
      Rs1      = 5'($urandom);
      Rs2      = 5'($urandom);
      Funct3   = 3'($urandom);
      Funct7   = 7'($urandom);
      Imm      = randImm();
   endtask

   initial begin
      modelReset();
      @(negedge CLK);
      @(negedge CLK);
      compareAll();
      check("rst_waddr", 32'(WAddr), 32'(BASE));
      check("rst_wdata", WData, 32'd0);
      Reset = 1'b0;

      // Single I-type word with in_last
      start = 1'b1; cycle(); start = 1'b0;
      drive(1, 1, 3'b001, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF); cycle();
      check("tp1_we", 32'(WE), 32'd1);
      check("tp1_waddr", 32'(WAddr), 32'd0);
      check("tp1_wdata", WData, 32'hFFF00093);
      check("tp1_count", 32'(count), 32'd1);
      check("tp1_no_done_yet", 32'(done), 32'd0);
      idle(); cycle();
      check("tp1_done", 32'(done), 32'd1);
      cycle();
      check("tp1_done_pulse", 32'(done), 32'd0);

      // Back-to-back S, B, U, J
      start = 1'b1; cycle(); start = 1'b0;
      drive(1, 0, 3'b010, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8); cycle();
      check("sw_waddr", 32'(WAddr), 32'd0);
      check("sw_wdata", WData, 32'h0020A423);
      drive(1, 0, 3'b011, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC); cycle();
      check("beq_waddr", 32'(WAddr), 32'd1);
      check("beq_wdata", WData, 32'hFE000EE3);
      drive(1, 0, 3'b100, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000); cycle();
      check("lui_waddr", 32'(WAddr), 32'd2);
      check("lui_wdata", WData, 32'h123452B7);
      drive(1, 1, 3'b101, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0); cycle();
      check("jal_waddr", 32'(WAddr), 32'd3);
      check("jal_wdata", WData, 32'h0000006F);
      check("stream_count", 32'(count), 32'd4);
      idle(); cycle(); cycle(); cycle();

      // Range error, then misaligned branch, start ignored mid-session
      start = 1'b1; cycle(); start = 1'b0;
      drive(1, 0, 3'b001, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048); cycle();
      check("rng_we", 32'(WE), 32'd0);
      check("rng_err", 32'(err), 32'd1);
      check("rng_code", 32'(err_code), 32'd1);
      drive(1, 0, 3'b011, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3); cycle();
      check("mis_we", 32'(WE), 32'd0);
      check("mis_code_kept", 32'(err_code), 32'd1);
      idle(); start = 1'b1; cycle(); start = 1'b0;
      check("start_ignored_err", 32'(err), 32'd1);
      drive(1, 1, 3'b001, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5); cycle();
      idle(); cycle();
      check("err_done", 32'(done), 32'd1);
      start = 1'b1; cycle(); start = 1'b0;
      check("start_clears_err", 32'(err), 32'd0);
      check("start_clears_code", 32'(err_code), 32'd0);

      // Illegal type ends the session without a write
      drive(1, 1, 3'b110, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0); cycle();
      check("bad_code", 32'(err_code), 32'd3);
      check("bad_count", 32'(count), 32'd0);
      check("bad_we", 32'(WE), 32'd0);
      idle(); cycle(); cycle(); cycle();

      // Overflow: five bundles without in_last into four words
      start = 1'b1; cycle(); start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 3'b001, 7'h13, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i));
         cycle();
      end
      check("ovf_ready", 32'(in_ready), 32'd0);
      check("ovf_count", 32'(count), 32'd4);
      drive(1, 0, 3'b001, 7'h13, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9); cycle();
      check("ovf_done", 32'(done), 32'd1);
      check("ovf_code", 32'(err_code), 32'd4);
      check("ovf_we", 32'(WE), 32'd0);
      idle(); cycle();

      // Reset right after a bundle is accepted drops the pending write
      start = 1'b1; cycle(); start = 1'b0;
      drive(1, 0, 3'b001, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
      @(posedge CLK);
      #1 Reset = 1'b1;
      #1;
      check("rst_mid_we", 32'(WE), 32'd0);
      check("rst_mid_count", 32'(count), 32'd0);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_ready", 32'(in_ready), 32'd0);
      check("rst_mid_waddr", 32'(WAddr), 32'(BASE));
      check("rst_mid_wdata", WData, 32'd0);
      modelReset();
      idle();
      @(negedge CLK);
      compareAll();
      Reset = 1'b0;

      // Randomized sessions
      for (int s = 0; s < 40; s++) begin
         idle(); start = 1'b1; cycle(); start = 1'b0;
         for (int k = 0; k < 20 && mPhase != 0; k++) begin
            randBundle();
            cycle();
         end
         idle();
         repeat (3) cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
